rv_regs_mp: RTL
===============

Name: rv_regs_mp

Overview:
- Parametrised general-purpose register file for the RV32 core, successor to the fixed 32x32, 2-read/1-write file.
- Provides configurable register count (RV32I=32 / RV32E=16), data width and number of read ports.
- Adds registered reads with write-first bypass, a pipeline hold input, and a post-reset hardware clear sequencer.
- Sits between decode (read addresses) and writeback (write port).

Parameters:
- XLEN, 32, data width of each register.
- REG_CNT, 32, number of architectural registers; legal values 16 or 32.
- RD_PORTS, 2, number of read ports, 1..4.

Ports:
- i_clk  in  1  clock.
- i_reset_n  in  1  synchronous active-low reset.
- i_hold  in  1  freeze read-side address/output registers (pipeline stall).
- i_rs  in  RD_PORTS*5  read addresses; port p at bits [5p+4:5p].
- i_rd  in  5  write address.
- i_write  in  1  write enable.
- i_data  in  XLEN  write data.
- o_data  out  RD_PORTS*XLEN  read data; port p at bits [XLEN*p+XLEN-1:XLEN*p].
- o_ready  out  1  high when clear sequence is done and the file is usable.

Behaviour:
- Reset: i_clk and i_reset_n as decided (synchronous, active-low). While i_reset_n=0:
  - FSM goes to CLEAR and the clear counter goes to 1.
  - o_ready=0; all read output registers and latched read addresses go to 0.
  - No array writes occur.
- FSM CLEAR:
  - Each cycle writes 0 to array[counter], then increments the counter.
  - When counter = REG_CNT-1 is written, go to RUN.
  - CLEAR lasts exactly REG_CNT-1 cycles after reset release.
  - o_ready is asserted (registered) the cycle after the last clear write.
  - In CLEAR, i_write is ignored and read outputs stay 0.
- FSM RUN: terminal until reset. Reset mid-RUN or mid-CLEAR restarts CLEAR from counter 1.
- Write (RUN only):
  - array[i_rd] <= i_data at the clock edge when i_write=1, i_rd != 0 and i_rd < REG_CNT.
  - If i_rd >= REG_CNT (only possible with REG_CNT=16), the write is dropped.
- Read, 1-cycle latency: each port registers its address and data.
  - o_data[p] in cycle N+1 reflects i_rs[p] sampled at edge N.
  - Address 0 or address >= REG_CNT returns 0.
- Bypass (write-first): if i_write=1 with valid i_rd equal to i_rs[p] on the same edge, port p captures i_data, not the old array value.
- Hold: while i_hold=1, latched addresses and o_data do not follow i_rs.
  - Exception: if a valid write targets a port's latched address, that port's o_data updates to i_data on that edge, so held operands stay coherent.
  - Writes to the array still occur during hold.
- Simultaneous hold + bypass on the same port: the write updates held data, as above.
- Multiple read ports may address the same register; each gets identical data.

Optional Feature:
- Macro: RV_REGS_TRACE_EN.
- Defined: adds ports i_rd_tr (in, 5) and o_rd_tr (out, XLEN).
  - o_rd_tr is a combinational read of array[i_rd_tr], with no bypass.
  - Address 0 or out-of-range returns 0.
  - Used for simulation/trace compare.
- Not defined: ports absent, no extra logic.

Test Plan:
- Release reset, REG_CNT=32 -> o_ready low for 31 cycles, high on the 32nd cycle after release; then reading x1..x31 returns 0x00000000.
- Write x5=0xDEADBEEF, next cycle read rs1=5 -> o_data port0 = 0xDEADBEEF one cycle after the address is presented.
- Same-edge write x7=0x12345678 and read rs2=7 -> next cycle port1 = 0x12345678 (bypass).
- Write x0=0xFFFFFFFF, then read rs1=0 -> 0; with REG_CNT=16, write x20=0xAA then read rs1=20 -> 0.
- Latch rs1=9 (value 0x11) and assert i_hold for 3 cycles.
  - Change i_rs to 3 -> o_data stays 0x11.
  - Write x9=0x22 during hold -> o_data becomes 0x22 on the next cycle.
- Reset asserted mid-RUN after writing x4=0x55 -> o_ready drops, CLEAR reruns, x4 reads 0 after o_ready returns.

Source files
------------

// File: rtl/rv_regs_mp.sv
// rv_regs_mp: parametrised RV32 general-purpose register file with registered
//   reads, write-first bypass, pipeline hold and a post-reset clear sequencer.
// Latency: 1 cycle from read address to o_data; writes land on the clock edge.
// Backpressure: i_hold freezes the read-side registers; o_ready stays low while
//   the clear sequence runs, and writes are ignored during that time.
//
// Ports:
//   i_clk, i_reset_n    clock, synchronous active-low reset
//   i_hold              freeze latched read addresses and o_data
//   i_rs                RD_PORTS x 5-bit read addresses (port p at [5p+4:5p])
//   i_rd/i_write/i_data write port
//   o_data              RD_PORTS x XLEN read data (port p at [XLEN*p +: XLEN])
//   o_ready             high once the clear sequence is done
//   i_rd_tr/o_rd_tr     combinational trace read port, only with RV_REGS_TRACE_EN
//
// Optional feature macro: RV_REGS_TRACE_EN (adds the trace read port).
module rv_regs_mp #(
  parameter int XLEN     = 32,
  parameter int REG_CNT  = 32,
  parameter int RD_PORTS = 2
) (
  input  logic                     i_clk,
  input  logic                     i_reset_n,
  input  logic                     i_hold,
  input  logic [RD_PORTS*5-1:0]    i_rs,
  input  logic [4:0]               i_rd,
  input  logic                     i_write,
  input  logic [XLEN-1:0]          i_data,
`ifdef RV_REGS_TRACE_EN
  input  logic [4:0]               i_rd_tr,
  output logic [XLEN-1:0]          o_rd_tr,
`endif
  output logic [RD_PORTS*XLEN-1:0] o_data,
  output logic                     o_ready
);

  localparam int         AW        = $clog2(REG_CNT);
  localparam logic [5:0] REG_CNT_V = 6'(REG_CNT);
  localparam logic [4:0] LAST_IDX  = 5'(REG_CNT - 1);

  typedef enum logic {ST_CLEAR, ST_RUN} state_t;

  state_t                            state_q;
  logic [4:0]                        cnt_q;
  logic                              ready_q;
  logic [XLEN-1:0]                   regs_q [REG_CNT];

  logic [RD_PORTS-1:0][4:0]          rs_vec;
  logic [RD_PORTS-1:0][4:0]          addr_q, addr_d;
  logic [RD_PORTS-1:0][XLEN-1:0]     data_q, data_d;
  logic                              wr_ok;

  // Register 0 is hardwired to zero and indices past REG_CNT do not exist.
  function automatic logic addr_ok(input logic [4:0] a);
    return (a != 5'd0) && ({1'b0, a} < REG_CNT_V);
  endfunction

  assign rs_vec = i_rs;
  assign wr_ok  = (state_q == ST_RUN) && i_write && addr_ok(i_rd);

  // Clear sequencer: x0 never needs clearing, so the counter starts at 1.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q <= ST_CLEAR;
      cnt_q   <= 5'd1;
      ready_q <= 1'b0;
    end else begin
      case (state_q)
        ST_CLEAR: begin
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == LAST_IDX) begin
            state_q <= ST_RUN;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_RUN;
        end
      endcase
    end
  end

  // Storage array: cleared entry by entry after reset, then the write port.
  always_ff @(posedge i_clk) begin
    if (i_reset_n) begin
      if (state_q == ST_CLEAR) begin
        regs_q[cnt_q[AW-1:0]] <= '0;
      end else if (wr_ok) begin
        regs_q[i_rd[AW-1:0]] <= i_data;
      end
    end
  end

  // Read side. A held port still tracks writes to its latched register so
  // stalled operands never go stale.
  always_comb begin
    addr_d = addr_q;
    data_d = data_q;
    for (int p = 0; p < RD_PORTS; p++) begin
      if (state_q != ST_RUN) begin
        addr_d[p] = 5'd0;
        data_d[p] = '0;
      end else if (!i_hold) begin
        addr_d[p] = rs_vec[p];
        if (wr_ok && (i_rd == rs_vec[p])) begin
          data_d[p] = i_data;
        end else if (addr_ok(rs_vec[p])) begin
          data_d[p] = regs_q[rs_vec[p][AW-1:0]];
        end else begin
          data_d[p] = '0;
        end
      end else if (wr_ok && (i_rd == addr_q[p])) begin
        data_d[p] = i_data;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      addr_q <= '0;
      data_q <= '0;
    end else begin
      addr_q <= addr_d;
      data_q <= data_d;
    end
  end

  assign o_data  = data_q;
  assign o_ready = ready_q;

`ifdef RV_REGS_TRACE_EN
  // Raw array view for trace compare; deliberately no bypass.
  assign o_rd_tr = addr_ok(i_rd_tr) ? regs_q[i_rd_tr[AW-1:0]] : '0;
`endif

endmodule
